// File: rtl/banked_mem_ctrl.sv
// banked_mem_ctrl: four-bank word-interleaved memory with bank = addr[2:1]. MEM_UNALIGNED_ERR_EN rejects odd addresses.
// Latency: read data appears RD_LAT cycles after accept. Distinct banks stream one access per cycle.
// Backpressure: stall is raised while the addressed bank is busy, and the requester holds the request.
module banked_mem_ctrl #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int RD_LAT   = 2,
    parameter int BUSY_CYC = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              stall,
    output logic [3:0]        busy,
    output logic              err
);
    localparam int CNT_W = $clog2(BUSY_CYC) + 1;
    localparam int WORDS = 1 << (ADDR_W - 1);

    logic [DATA_W-1:0] mem [WORDS];
    logic [CNT_W-1:0]  busy_cnt [4];
    logic [RD_LAT-1:0] rd_vld_pipe;
    logic [DATA_W-1:0] rd_dat_pipe [RD_LAT];
    logic              req;
    logic              unaligned;
    logic              accept;
    logic [1:0]        bank;
    logic [ADDR_W-2:0] word_addr;

    assign req       = rd ^ wr;
    assign bank      = addr[2:1];
    assign word_addr = addr[ADDR_W-1:1];

`ifdef MEM_UNALIGNED_ERR_EN
    assign unaligned = req & addr[0];
`else
    // Byte offset is ignored: every access is a word access to addr & ~1.
    logic unused_addr0;
    assign unused_addr0 = addr[0];
    assign unaligned    = 1'b0;
`endif

    // An errored request neither stalls nor occupies a bank.
    assign err    = (rd & wr) | unaligned;
    assign stall  = req & ~err & busy[bank];
    assign accept = req & ~err & ~busy[bank];

    always_comb begin
        busy = '0;
        for (int b = 0; b < 4; b++) begin
            busy[b] = (busy_cnt[b] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 4; b++) begin
                busy_cnt[b] <= '0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (accept && bank == 2'(b)) begin
                    busy_cnt[b] <= CNT_W'(BUSY_CYC - 1);
                end else if (busy_cnt[b] != '0) begin
                    busy_cnt[b] <= busy_cnt[b] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_pipe <= '0;
        end else begin
            rd_vld_pipe[0] <= accept & rd;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_vld_pipe[i] <= rd_vld_pipe[i-1];
            end
        end
    end

    // Storage and read data are not reset; validity is tracked by rd_vld_pipe alone.
    always_ff @(posedge clk) begin
        if (accept && wr) begin
            mem[word_addr] <= data_in;
        end
        if (accept && rd) begin
            rd_dat_pipe[0] <= mem[word_addr];
        end
        for (int i = 1; i < RD_LAT; i++) begin
            rd_dat_pipe[i] <= rd_dat_pipe[i-1];
        end
    end

    assign rd_valid = rd_vld_pipe[RD_LAT-1];
    assign data_out = rd_valid ? rd_dat_pipe[RD_LAT-1] : '0;

endmodule

// File: tb/tb_banked_mem_ctrl.sv
// tb_banked_mem_ctrl: directed vectors for banked_mem_ctrl with hand-computed expectations.
module tb_banked_mem_ctrl;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              stall;
    logic [3:0]        busy;
    logic              err;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    banked_mem_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd       (rd),
        .wr       (wr),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .rd_valid (rd_valid),
        .stall    (stall),
        .busy     (busy),
        .err      (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drive one cycle's request after the edge, then sample mid-cycle.
    task automatic cyc(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
        @(posedge clk);
        #1;
        rd      = r;
        wr      = w;
        addr    = a;
        data_in = d;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    logic [15:0] fill_dat [4];

    initial begin
        fill_dat[0] = 16'h1111;
        fill_dat[1] = 16'h2222;
        fill_dat[2] = 16'h3333;
        fill_dat[3] = 16'h4444;

        rst_n   = 1'b0;
        rd      = 1'b0;
        wr      = 1'b0;
        addr    = '0;
        data_in = '0;
        @(negedge clk);
        chk("rst_data_out", 32'(data_out), 32'h0);
        chk("rst_rd_valid", 32'(rd_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Preload, ordered so no bank is revisited within 4 cycles.
        cyc(1'b0, 1'b1, 16'h0048, 16'h1234);
        chk("pre_stall0", 32'(stall), 32'h0);
        cyc(1'b0, 1'b1, 16'h0004, 16'h6666);
        cyc(1'b0, 1'b1, 16'h0006, 16'h7777);
        cyc(1'b0, 1'b1, 16'h0122, fill_dat[1]);
        cyc(1'b0, 1'b1, 16'h0120, fill_dat[0]);
        chk("pre_stall4", 32'(stall), 32'h0);
        cyc(1'b0, 1'b1, 16'h0124, fill_dat[2]);
        cyc(1'b0, 1'b1, 16'h0126, fill_dat[3]);
        chk("pre_stall6", 32'(stall), 32'h0);
        idle(4);

        // Write then read-back on the same bank once it is free.
        cyc(1'b0, 1'b1, 16'h0010, 16'hBEEF);
        chk("t1_wr_stall", 32'(stall), 32'h0);
        for (int i = 1; i <= 3; i++) begin
            idle(1);
            chk("t1_busy0", 32'(busy[0]), 32'h1);
        end
        cyc(1'b1, 1'b0, 16'h0010, 16'h0000);
        chk("t1_rd_stall", 32'(stall), 32'h0);
        chk("t1_busy0_free", 32'(busy[0]), 32'h0);
        idle(1);
        chk("t1_vld_early", 32'(rd_valid), 32'h0);
        chk("t1_dout_zero", 32'(data_out), 32'h0);
        idle(1);
        chk("t1_vld", 32'(rd_valid), 32'h1);
        chk("t1_data", 32'(data_out), 32'hBEEF);
        idle(1);
        chk("t1_vld_off", 32'(rd_valid), 32'h0);
        idle(3);

        // Line fill across all four banks.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 16'(16'h0120 + 2 * i), 16'h0000);
            chk("t2_stall", 32'(stall), 32'h0);
            if (i == 3) chk("t2_busy_t3", 32'(busy), 32'h7);
            if (i >= 2) begin
                chk("t2_vld", 32'(rd_valid), 32'h1);
                chk("t2_data", 32'(data_out), 32'(fill_dat[i-2]));
            end else begin
                chk("t2_vld_early", 32'(rd_valid), 32'h0);
            end
        end
        idle(1);
        chk("t2_busy_t4", 32'(busy), 32'hE);
        chk("t2_vld4", 32'(rd_valid), 32'h1);
        chk("t2_data4", 32'(data_out), 32'(fill_dat[2]));
        idle(1);
        chk("t2_vld5", 32'(rd_valid), 32'h1);
        chk("t2_data5", 32'(data_out), 32'(fill_dat[3]));
        idle(1);
        chk("t2_vld_off", 32'(rd_valid), 32'h0);
        idle(3);

        // Same-bank conflict: held read stalls until the bank frees.
        cyc(1'b0, 1'b1, 16'h0040, 16'h5A5A);
        chk("t3_wr_stall", 32'(stall), 32'h0);
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b1, 1'b0, 16'h0048, 16'h0000);
            chk("t3_stall", 32'(stall), 32'h1);
            chk("t3_busy0", 32'(busy[0]), 32'h1);
            chk("t3_no_vld", 32'(rd_valid), 32'h0);
        end
        cyc(1'b1, 1'b0, 16'h0048, 16'h0000);
        chk("t3_accept", 32'(stall), 32'h0);
        chk("t3_no_vld4", 32'(rd_valid), 32'h0);
        idle(1);
        chk("t3_no_vld5", 32'(rd_valid), 32'h0);
        idle(1);
        chk("t3_vld", 32'(rd_valid), 32'h1);
        chk("t3_data", 32'(data_out), 32'h1234);
        idle(3);

        // rd and wr together is illegal.
        cyc(1'b1, 1'b1, 16'h0002, 16'hAAAA);
        chk("t4_err", 32'(err), 32'h1);
        chk("t4_stall", 32'(stall), 32'h0);
        chk("t4_busy", 32'(busy), 32'h0);
        idle(1);
        chk("t4_err_clr", 32'(err), 32'h0);
        chk("t4_busy_after", 32'(busy), 32'h0);
        chk("t4_no_vld1", 32'(rd_valid), 32'h0);
        idle(1);
        chk("t4_no_vld2", 32'(rd_valid), 32'h0);

        // Reset while a read is in flight.
        cyc(1'b1, 1'b0, 16'h0006, 16'h0000);
        chk("t5_stall", 32'(stall), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        rd    = 1'b0;
        @(negedge clk);
        chk("t5_rst_busy", 32'(busy), 32'h0);
        chk("t5_rst_vld", 32'(rd_valid), 32'h0);
        chk("t5_rst_dout", 32'(data_out), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t5_no_vld2", 32'(rd_valid), 32'h0);
        idle(1);
        chk("t5_no_vld3", 32'(rd_valid), 32'h0);
        cyc(1'b1, 1'b0, 16'h0004, 16'h0000);
        cyc(1'b1, 1'b0, 16'h0006, 16'h0000);
        chk("t5_b3_free", 32'(stall), 32'h0);
        idle(1);
        chk("t5_kept_vld", 32'(rd_valid), 32'h1);
        chk("t5_kept_0004", 32'(data_out), 32'h6666);
        idle(1);
        chk("t5_kept_0006", 32'(data_out), 32'h7777);
        idle(3);

        // Odd byte address.
        cyc(1'b1, 1'b0, 16'h0011, 16'h0000);
`ifdef MEM_UNALIGNED_ERR_EN
        chk("t6_err", 32'(err), 32'h1);
        chk("t6_stall", 32'(stall), 32'h0);
        idle(1);
        chk("t6_busy", 32'(busy), 32'h0);
        idle(1);
        chk("t6_no_vld", 32'(rd_valid), 32'h0);
`else
        chk("t6_err", 32'(err), 32'h0);
        chk("t6_stall", 32'(stall), 32'h0);
        idle(2);
        chk("t6_vld", 32'(rd_valid), 32'h1);
        chk("t6_data", 32'(data_out), 32'hBEEF);
`endif
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
